// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared widths, load size codes, load FSM states and result assembly
package reg_writeback_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} ld_state_t;
  function automatic logic [DATA_W-1:0] assemble(input logic [1:0] size, input logic sgn,
                                                 input logic [DATA_W-1:0] raw);
    return size == LD_B ? {{24{sgn & raw[7]}}, raw[7:0]} :
           size == LD_H ? {{16{sgn & raw[15]}}, raw[15:0]} : raw;
  endfunction
  function automatic logic [2:0] byte_target(input logic [1:0] size);
    return size == LD_B ? 3'd1 : size == LD_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous {rd, data} FIFO exposing per-entry valid/rd for the pending mask
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic                                 pop,
  input  logic [REG_ADDR_W-1:0]                push_rd,
  input  logic [DATA_W-1:0]                    push_data,
  output logic                                 full,
  output logic                                 empty,
  output logic [REG_ADDR_W-1:0]                head_rd,
  output logic [DATA_W-1:0]                    head_data,
  output logic [DEPTH-1:0]                     valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     rds
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr, count;
  logic [REG_ADDR_W-1:0] rd_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  assign count = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_rd = rd_mem[rptr[AW-1:0]];
  assign head_data = data_mem[rptr[AW-1:0]];
  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        rd_mem[wptr[AW-1:0]] <= push_rd;
        data_mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
  // an entry is live when its distance from the read pointer is below the fill count
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off = AW'(i) - rptr[AW-1:0];
    assign valid[i] = {1'b0, off} < count;
    assign rds[i] = rd_mem[i];
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and byte-serial load results into one register write port
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  ld_start,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  output logic                  ld_busy,
  input  logic                  mem_byte_valid,
  input  logic [7:0]            mem_byte,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] regw_addr,
  output logic [DATA_W-1:0]     regw_data,
  output logic [31:0]           pending
);
  ld_state_t state, next;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0] size_q;
  logic signed_q;
  logic [DATA_W-1:0] raw;
  logic [2:0] k;
  logic full, empty, ld_push, alu_push;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [FIFO_DEPTH-1:0] valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] rds;
  logic [31:0] pend;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      rd_q <= '0;
      size_q <= '0;
      signed_q <= 1'b0;
      raw <= '0;
      k <= '0;
    end else begin
      state <= next;
      if (state == IDLE && ld_start) begin
        rd_q <= ld_rd;
        size_q <= ld_size;
        signed_q <= ld_signed;
        raw <= '0;
        k <= '0;
      end
      if (state == COLLECT && mem_byte_valid) begin
        raw[{k[1:0], 3'b000} +: 8] <= mem_byte;
        k <= k + 3'd1;
      end
    end
  end
  always_comb begin
    next = state == IDLE    ? (ld_start ? COLLECT : IDLE) :
           state == COLLECT ? ((mem_byte_valid && k + 3'd1 == byte_target(size_q)) ? DONE : COLLECT) :
           (full ? DONE : IDLE);
  end
  assign ld_busy = state != IDLE;
  // a load to x0 still leaves DONE when space exists, it just drops the result
  assign ld_push = state == DONE && !full && rd_q != '0;
  assign alu_ready = !full && state != DONE;
  assign alu_push = alu_valid && alu_ready && alu_rd != '0;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(ld_push || alu_push),
    .pop(!empty),
    .push_rd(ld_push ? rd_q : alu_rd),
    .push_data(ld_push ? assemble(size_q, signed_q, raw) : alu_data),
    .full(full),
    .empty(empty),
    .head_rd(head_rd),
    .head_data(head_data),
    .valid(valid),
    .rds(rds)
  );
  assign write = !empty;
  assign regw_addr = empty ? '0 : head_rd;
  assign regw_data = empty ? '0 : head_data;
  always_comb begin
    pend = ld_busy ? (32'd1 << rd_q) : 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) pend = valid[i] ? (pend | (32'd1 << rds[i])) : pend;
  end
  assign pending = pend & ~32'd1;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenario tasks with hand-computed expectations
module tb_reg_writeback;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic alu_valid = 1'b0;
  logic [4:0] alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic alu_ready;
  logic ld_start = 1'b0;
  logic [4:0] ld_rd = '0;
  logic [1:0] ld_size = '0;
  logic ld_signed = 1'b0;
  logic ld_busy;
  logic mem_byte_valid = 1'b0;
  logic [7:0] mem_byte = '0;
  logic write;
  logic [4:0] regw_addr;
  logic [31:0] regw_data;
  logic [31:0] pending;
  int checks = 0;
  int errors = 0;

  reg_writeback #(.FIFO_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_start(ld_start), .ld_rd(ld_rd), .ld_size(ld_size), .ld_signed(ld_signed), .ld_busy(ld_busy),
    .mem_byte_valid(mem_byte_valid), .mem_byte(mem_byte),
    .write(write), .regw_addr(regw_addr), .regw_data(regw_data), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step(); step();
    checks++;
    if ({write, regw_addr, regw_data} !== {1'b1 ^ 1'b1, 5'd0, 32'd0}) begin
      errors++; $display("FAIL reset_write: got %b/%0d/%h want 0/0/0", write, regw_addr, regw_data);
    end
    checks++;
    if ({pending, ld_busy, alu_ready} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_status: pending=%h busy=%b ready=%b want 0/0/1", pending, ld_busy, alu_ready);
    end
    reset = 1'b1;
    step();
    alu_valid = 1'b0;
    checks++;
    if ({write, regw_addr, regw_data} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL reset_first_alu: got %b/%0d/%h want 1/5/00001234", write, regw_addr, regw_data);
    end
    checks++;
    if (pending !== 32'h20) begin
      errors++; $display("FAIL reset_alu_pending: got %h want 00000020", pending);
    end
    step();
    checks++;
    if ({write, pending} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL reset_alu_drain: write=%b pending=%h want 0/0", write, pending);
    end
  endtask

  task automatic test_byte_load(input logic sgn, input logic [31:0] exp);
    ld_start = 1'b1; ld_rd = 5'd7; ld_size = 2'd0; ld_signed = sgn;
    step();
    ld_start = 1'b0;
    checks++;
    if ({ld_busy, pending} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL byte_collect: busy=%b pending=%h want 1/00000080", ld_busy, pending);
    end
    mem_byte_valid = 1'b1; mem_byte = 8'h80;
    step();
    mem_byte_valid = 1'b0;
    checks++;
    if ({write, ld_busy, alu_ready, pending} !== {1'b0, 1'b1, 1'b0, 32'h80}) begin
      errors++; $display("FAIL byte_done: write=%b busy=%b ready=%b pending=%h want 0/1/0/00000080",
                         write, ld_busy, alu_ready, pending);
    end
    step();
    checks++;
    if ({write, regw_addr, regw_data} !== {1'b1, 5'd7, exp}) begin
      errors++; $display("FAIL byte_write s=%b: got %b/%0d/%h want 1/7/%h", sgn, write, regw_addr, regw_data, exp);
    end
    checks++;
    if ({ld_busy, pending} !== {1'b0, 32'h80}) begin
      errors++; $display("FAIL byte_pending_at_write: busy=%b pending=%h want 0/00000080", ld_busy, pending);
    end
    step();
    checks++;
    if ({write, pending} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL byte_drain: write=%b pending=%h want 0/0", write, pending);
    end
  endtask

  task automatic test_word_load();
    logic [7:0] bytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    ld_start = 1'b1; ld_rd = 5'd9; ld_size = 2'd2; ld_signed = 1'b1;
    step();
    ld_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_byte_valid = 1'b0; mem_byte = 8'hEE;
      step(); step();
      mem_byte_valid = 1'b1; mem_byte = bytes[b];
      step();
    end
    mem_byte_valid = 1'b0;
    checks++;
    if ({write, ld_busy, pending} !== {1'b0, 1'b1, 32'h200}) begin
      errors++; $display("FAIL word_done: write=%b busy=%b pending=%h want 0/1/00000200", write, ld_busy, pending);
    end
    step();
    checks++;
    if ({write, regw_addr, regw_data, ld_busy} !== {1'b1, 5'd9, 32'h12345678, 1'b0}) begin
      errors++; $display("FAIL word_write: got %b/%0d/%h busy=%b want 1/9/12345678 busy=0",
                         write, regw_addr, regw_data, ld_busy);
    end
    step();
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL word_single: write=%b want 0", write);
    end
  endtask

  task automatic test_collision();
    ld_start = 1'b1; ld_rd = 5'd4; ld_size = 2'd0; ld_signed = 1'b0;
    step();
    ld_start = 1'b0;
    mem_byte_valid = 1'b1; mem_byte = 8'h5A;
    step();
    mem_byte_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
    checks++;
    if (alu_ready !== 1'b0) begin
      errors++; $display("FAIL coll_stall: alu_ready=%b want 0", alu_ready);
    end
    step();
    checks++;
    if ({write, regw_addr, regw_data, alu_ready} !== {1'b1, 5'd4, 32'h5A, 1'b1}) begin
      errors++; $display("FAIL coll_load_first: got %b/%0d/%h ready=%b want 1/4/0000005a ready=1",
                         write, regw_addr, regw_data, alu_ready);
    end
    step();
    alu_valid = 1'b0;
    checks++;
    if ({write, regw_addr, regw_data} !== {1'b1, 5'd3, 32'hAA}) begin
      errors++; $display("FAIL coll_alu_next: got %b/%0d/%h want 1/3/000000aa", write, regw_addr, regw_data);
    end
    step();
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL coll_drain: write=%b want 0", write);
    end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      alu_rd = 5'(i); alu_data = 32'h11 * i;
      checks++;
      if (alu_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready %0d: alu_ready=%b want 1", i, alu_ready);
      end
      step();
      checks++;
      if ({write, regw_addr, regw_data} !== {1'b1, 5'(i), 32'h11 * i}) begin
        errors++; $display("FAIL b2b_write %0d: got %b/%0d/%h want 1/%0d/%h",
                           i, write, regw_addr, regw_data, i, 32'h11 * i);
      end
    end
    alu_valid = 1'b0;
    step();
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: write=%b want 0", write);
    end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_alu_ready: alu_ready=%b want 1", alu_ready);
    end
    step();
    alu_valid = 1'b0;
    checks++;
    if ({write, pending} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL x0_alu_nowrite: write=%b pending=%h want 0/0", write, pending);
    end
    ld_start = 1'b1; ld_rd = 5'd0; ld_size = 2'd1; ld_signed = 1'b1;
    step();
    ld_start = 1'b0;
    checks++;
    if ({ld_busy, pending} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL x0_ld_busy: busy=%b pending=%h want 1/0", ld_busy, pending);
    end
    mem_byte_valid = 1'b1; mem_byte = 8'h01;
    step();
    mem_byte = 8'h80;
    step();
    mem_byte_valid = 1'b0;
    checks++;
    if ({ld_busy, write} !== {1'b1, 1'b0}) begin
      errors++; $display("FAIL x0_ld_done: busy=%b write=%b want 1/0", ld_busy, write);
    end
    step();
    checks++;
    if ({ld_busy, write} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL x0_ld_retire: busy=%b write=%b want 0/0", ld_busy, write);
    end
    step();
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL x0_ld_nowrite: write=%b want 0", write);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1; ld_rd = 5'd10; ld_size = 2'd2; ld_signed = 1'b0;
    step();
    ld_start = 1'b0;
    mem_byte_valid = 1'b1; mem_byte = 8'hAA;
    step();
    mem_byte = 8'hBB;
    step();
    mem_byte_valid = 1'b0;
    checks++;
    if ({ld_busy, pending} !== {1'b1, 32'h400}) begin
      errors++; $display("FAIL midrst_before: busy=%b pending=%h want 1/00000400", ld_busy, pending);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({ld_busy, pending, write} !== {1'b0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL midrst_after: busy=%b pending=%h write=%b want 0/0/0", ld_busy, pending, write);
    end
    mem_byte_valid = 1'b1; mem_byte = 8'hCC;
    step(); step();
    mem_byte_valid = 1'b0;
    checks++;
    if ({ld_busy, write} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL midrst_stray: busy=%b write=%b want 0/0", ld_busy, write);
    end
    ld_start = 1'b1; ld_rd = 5'd11; ld_size = 2'd1; ld_signed = 1'b1;
    step();
    ld_start = 1'b0;
    mem_byte_valid = 1'b1; mem_byte = 8'h34;
    step();
    mem_byte = 8'h92;
    step();
    mem_byte_valid = 1'b0;
    step();
    checks++;
    if ({write, regw_addr, regw_data} !== {1'b1, 5'd11, 32'hFFFF9234}) begin
      errors++; $display("FAIL midrst_reload: got %b/%0d/%h want 1/11/ffff9234", write, regw_addr, regw_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_byte_load(1'b1, 32'hFFFFFF80);
    test_byte_load(1'b0, 32'h00000080);
    test_word_load();
    test_collision();
    test_back_to_back();
    test_x0();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
